// File: rtl/uart_mode_ctrl_pkg.sv
// Shared constants and helpers for the simple-uart mode controller:
// FSM state encodings, default timing parameters and the status-LED encoder.
package uart_mode_ctrl_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF  = 1_250_000;
  localparam int unsigned DONE_HOLD_CYCLES_DEF = 12_500_000;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RX_ON   = 3'd1;
  localparam logic [2:0] ST_TX_SEND = 3'd2;
  localparam logic [2:0] ST_TX_WAIT = 3'd3;
  localparam logic [2:0] ST_TX_ON   = 3'd4;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  localparam rgb_t RGB_RED = '{r: 1'b1, g: 1'b0, b: 1'b0};

  function automatic logic is_tx_mode(input logic [2:0] st);
    return (st == ST_TX_SEND) || (st == ST_TX_WAIT) || (st == ST_TX_ON);
  endfunction

  // Blue (done hold) overrides green (mode active); red otherwise, one-hot.
  function automatic rgb_t status_rgb(input logic hold, input logic active);
    rgb_t c;
    c.b = hold;
    c.g = !hold && active;
    c.r = !hold && !active;
    return c;
  endfunction

endpackage

// File: rtl/uart_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, consecutive-sample debounce and a
// one-cycle pulse on each debounced rising edge.
module uart_btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          level_dly_q;
  logic          press_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any sample that agrees with the accepted level restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/uart_mode_ctrl.sv
// Mode controller: keeps receiver and transmitter modes mutually exclusive,
// sequences one transmission of the switch byte and drives the status LEDs.
module uart_mode_ctrl
  import uart_mode_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES  = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned DONE_HOLD_CYCLES = DONE_HOLD_CYCLES_DEF
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic [3:2] btn,
  input  logic [3:0] sw,
  input  logic       tx_done,
  input  logic       rx_valid,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       rx_en,
  output logic [3:0] led,
  output logic       led5_r,
  output logic       led5_g,
  output logic       led5_b,
  output logic       led6_r,
  output logic       led6_g,
  output logic       led6_b,
  output logic [2:0] state_o
);

  localparam int unsigned HW = $clog2(DONE_HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(DONE_HOLD_CYCLES);

  logic          press_rx, press_tx;
  logic          level_rx, level_tx;
  logic [3:0]    sw_sync1_q, sw_sync2_q;
  logic [2:0]    state_q, state_d;
  logic [HW-1:0] tx_hold_q, tx_hold_d;
  logic [HW-1:0] rx_hold_q, rx_hold_d;
  logic          tx_start_q;
  logic [7:0]    tx_data_q;
  logic          rx_en_q;
  logic [3:0]    led_q;
  rgb_t          led5_q, led5_d;
  rgb_t          led6_q, led6_d;

  uart_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rx (
    .clk_i   (sysclk),
    .rst_ni  (rst_n),
    .btn_i   (btn[3]),
    .level_o (level_rx),
    .press_o (press_rx)
  );

  uart_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_tx (
    .clk_i   (sysclk),
    .rst_ni  (rst_n),
    .btn_i   (btn[2]),
    .level_o (level_tx),
    .press_o (press_tx)
  );

  // Transmitter handshake: tx_start is a one-cycle request with tx_data valid
  // in that cycle and held afterwards; tx_done is a one-cycle completion pulse.
  // There is no back-pressure: the transmitter must accept every tx_start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (press_rx)      state_d = ST_RX_ON;
        else if (press_tx) state_d = ST_TX_SEND;
      end
      ST_RX_ON:   if (press_rx) state_d = ST_IDLE;
      ST_TX_SEND: state_d = ST_TX_WAIT;
      ST_TX_WAIT: if (tx_done) state_d = ST_TX_ON;
      ST_TX_ON:   if (press_tx) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Hold timers are cleared on leaving their mode and reloaded by each event.
  always_comb begin
    tx_hold_d = tx_hold_q;
    if (!is_tx_mode(state_d)) begin
      tx_hold_d = '0;
    end else if (tx_done && is_tx_mode(state_q)) begin
      tx_hold_d = HOLD_LOAD;
    end else if (tx_hold_q != '0) begin
      tx_hold_d = tx_hold_q - 1'b1;
    end

    rx_hold_d = rx_hold_q;
    if (state_d != ST_RX_ON) begin
      rx_hold_d = '0;
    end else if (rx_valid && (state_q == ST_RX_ON)) begin
      rx_hold_d = HOLD_LOAD;
    end else if (rx_hold_q != '0) begin
      rx_hold_d = rx_hold_q - 1'b1;
    end

    led5_d = status_rgb(tx_hold_d != '0, is_tx_mode(state_d));
    led6_d = status_rgb(rx_hold_d != '0, state_d == ST_RX_ON);
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
      state_q    <= ST_IDLE;
      tx_hold_q  <= '0;
      rx_hold_q  <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      rx_en_q    <= 1'b0;
      led_q      <= 4'h0;
      led5_q     <= RGB_RED;
      led6_q     <= RGB_RED;
    end else begin
      sw_sync1_q <= sw;
      sw_sync2_q <= sw_sync1_q;
      state_q    <= state_d;
      tx_hold_q  <= tx_hold_d;
      rx_hold_q  <= rx_hold_d;
      tx_start_q <= (state_q == ST_TX_SEND);
      if (state_q == ST_TX_SEND) begin
        tx_data_q <= {4'b0000, sw_sync2_q};
      end
      rx_en_q    <= (state_d == ST_RX_ON);
      led_q      <= sw_sync2_q;
      led5_q     <= led5_d;
      led6_q     <= led6_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign rx_en    = rx_en_q;
  assign led      = led_q;
  assign led5_r   = led5_q.r;
  assign led5_g   = led5_q.g;
  assign led5_b   = led5_q.b;
  assign led6_r   = led6_q.r;
  assign led6_g   = led6_q.g;
  assign led6_b   = led6_q.b;
  assign state_o  = state_q;

endmodule

// File: tb/tb_uart_mode_ctrl.sv
// Bench for uart_mode_ctrl: directed vector table, hand-written corner
// sequences and randomized actions checked against an event-level mode model.
module tb_uart_mode_ctrl;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int PRESS_HOLD = DEB + 6;

  localparam int A_NONE = 0, A_PRX = 1, A_PTX = 2, A_RXV = 3, A_TXD = 4, A_SW = 5, A_BOTH = 6;
  localparam logic [2:0] M_IDLE = 3'd0, M_RX = 3'd1, M_TXW = 3'd3, M_TXON = 3'd4;
  localparam logic [2:0] C_RED = 3'b100, C_GRN = 3'b010, C_BLU = 3'b001;

  logic       sysclk = 1'b0;
  logic       rst_n;
  logic [3:2] btn;
  logic [3:0] sw;
  logic       tx_done, rx_valid;
  logic       tx_start, rx_en;
  logic [7:0] tx_data;
  logic [3:0] led;
  logic       led5_r, led5_g, led5_b, led6_r, led6_g, led6_b;
  logic [2:0] state_o;

  uart_mode_ctrl #(.DEBOUNCE_CYCLES(DEB), .DONE_HOLD_CYCLES(HOLD)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .btn(btn), .sw(sw),
    .tx_done(tx_done), .rx_valid(rx_valid),
    .tx_start(tx_start), .tx_data(tx_data), .rx_en(rx_en), .led(led),
    .led5_r(led5_r), .led5_g(led5_g), .led5_b(led5_b),
    .led6_r(led6_r), .led6_g(led6_g), .led6_b(led6_b),
    .state_o(state_o)
  );

  // ---------------- clock ----------------
  always #5 sysclk = ~sysclk;

  // ---------------- bookkeeping / model ----------------
  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  logic [7:0] exp_q[$];

  logic [2:0] m_mode = M_IDLE;
  logic [3:0] m_sw = 4'h0;
  logic [7:0] m_txd = 8'h00;
  int m_hold_tx = 0;
  int m_hold_rx = 0;

  typedef struct {
    int         act;
    logic [3:0] arg;
    int         wait_n;
    logic [2:0] st;
    logic       rx;
    logic [2:0] l5;
    logic [2:0] l6;
    logic [3:0] ld;
    logic [7:0] txd;
    int         starts;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Samples just after each rising edge; the scoreboard consumes tx_start.
  task automatic tick();
    @(posedge sysclk);
    #1;
    if (tx_start) begin
      start_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tx_start_unexpected: got tx_data %0h expected no pulse", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          errors++;
          $display("FAIL tx_start_data: got %0h expected %0h", tx_data, e);
        end
      end
    end
    if (m_hold_tx > 0) m_hold_tx--;
    if (m_hold_rx > 0) m_hold_rx--;
  endtask

  task automatic check_outputs(input string tag, input logic [2:0] st, input logic rx,
                               input logic [2:0] l5, input logic [2:0] l6,
                               input logic [3:0] ld, input logic [7:0] txd);
    check({tag, ".state"}, state_o, st);
    check({tag, ".rx_en"}, rx_en, rx);
    check({tag, ".led5"}, {led5_r, led5_g, led5_b}, l5);
    check({tag, ".led6"}, {led6_r, led6_g, led6_b}, l6);
    check({tag, ".led"}, led, ld);
    check({tag, ".tx_data"}, tx_data, txd);
  endtask

  function automatic logic [2:0] exp_rgb(input int hold, input logic active);
    if (hold > 0) return C_BLU;
    return active ? C_GRN : C_RED;
  endfunction

  // Mode rules applied per debounced press event.
  task automatic model_press(input logic rx, input logic tx);
    case (m_mode)
      M_IDLE: begin
        if (rx) m_mode = M_RX;
        else if (tx) begin
          m_mode = M_TXW;
          m_txd = {4'h0, m_sw};
          exp_q.push_back(m_txd);
        end
      end
      M_RX:   if (rx) begin m_mode = M_IDLE; m_hold_rx = 0; end
      M_TXON: if (tx) begin m_mode = M_IDLE; m_hold_tx = 0; end
      default: ;
    endcase
  endtask

  // ---------------- driver ----------------
  task automatic press(input logic b3, input logic b2);
    btn = {b3, b2};
    repeat (PRESS_HOLD) tick();
    btn = 2'b00;
    repeat (PRESS_HOLD) tick();
  endtask

  task automatic do_action(input int act, input logic [3:0] arg, input int wait_n);
    case (act)
      A_SW:   begin sw = arg; m_sw = arg; end
      A_PRX:  begin model_press(1'b1, 1'b0); press(1'b1, 1'b0); end
      A_PTX:  begin model_press(1'b0, 1'b1); press(1'b0, 1'b1); end
      A_BOTH: begin model_press(1'b1, 1'b1); press(1'b1, 1'b1); end
      A_RXV: begin
        rx_valid = 1'b1; tick(); rx_valid = 1'b0;
        if (m_mode == M_RX) m_hold_rx = HOLD;
      end
      A_TXD: begin
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        if (m_mode == M_TXW) m_mode = M_TXON;
        if (m_mode == M_TXON) m_hold_tx = HOLD;
      end
      default: ;
    endcase
    repeat (wait_n) tick();
  endtask

  task automatic check_model(input string tag);
    check_outputs(tag, m_mode, m_mode == M_RX,
                  exp_rgb(m_hold_tx, (m_mode == M_TXW) || (m_mode == M_TXON)),
                  exp_rgb(m_hold_rx, m_mode == M_RX), m_sw, m_txd);
  endtask

  task automatic add_vec(input int act, input logic [3:0] arg, input int w,
                         input logic [2:0] st, input logic rx, input logic [2:0] l5,
                         input logic [2:0] l6, input logic [3:0] ld, input logic [7:0] txd,
                         input int starts);
    vec_t v;
    v.act = act; v.arg = arg; v.wait_n = w; v.st = st; v.rx = rx;
    v.l5 = l5; v.l6 = l6; v.ld = ld; v.txd = txd; v.starts = starts;
    vecs.push_back(v);
  endtask

  // ---------------- test ----------------
  initial begin
    rst_n = 1'b0; btn = 2'b00; sw = 4'h0; tx_done = 1'b0; rx_valid = 1'b0;

    //            act     arg   w  state   rx  led5   led6   led   txd    starts
    add_vec(A_SW,   4'hA, 4, M_IDLE, 0, C_RED, C_RED, 4'hA, 8'h00, 0);
    add_vec(A_PTX,  4'h0, 0, M_TXW,  0, C_GRN, C_RED, 4'hA, 8'h0A, 1);
    add_vec(A_PTX,  4'h0, 0, M_TXW,  0, C_GRN, C_RED, 4'hA, 8'h0A, 0);
    add_vec(A_TXD,  4'h0, 0, M_TXON, 0, C_BLU, C_RED, 4'hA, 8'h0A, 0);
    add_vec(A_NONE, 4'h0, 7, M_TXON, 0, C_BLU, C_RED, 4'hA, 8'h0A, 0);
    add_vec(A_NONE, 4'h0, 1, M_TXON, 0, C_GRN, C_RED, 4'hA, 8'h0A, 0);
    add_vec(A_PRX,  4'h0, 0, M_TXON, 0, C_GRN, C_RED, 4'hA, 8'h0A, 0);
    add_vec(A_PTX,  4'h0, 0, M_IDLE, 0, C_RED, C_RED, 4'hA, 8'h0A, 0);
    add_vec(A_PRX,  4'h0, 0, M_RX,   1, C_RED, C_GRN, 4'hA, 8'h0A, 0);
    add_vec(A_PTX,  4'h0, 0, M_RX,   1, C_RED, C_GRN, 4'hA, 8'h0A, 0);
    add_vec(A_RXV,  4'h0, 0, M_RX,   1, C_RED, C_BLU, 4'hA, 8'h0A, 0);
    add_vec(A_NONE, 4'h0, 8, M_RX,   1, C_RED, C_GRN, 4'hA, 8'h0A, 0);
    add_vec(A_RXV,  4'h0, 3, M_RX,   1, C_RED, C_BLU, 4'hA, 8'h0A, 0);
    add_vec(A_RXV,  4'h0, 7, M_RX,   1, C_RED, C_BLU, 4'hA, 8'h0A, 0);
    add_vec(A_NONE, 4'h0, 1, M_RX,   1, C_RED, C_GRN, 4'hA, 8'h0A, 0);
    add_vec(A_PRX,  4'h0, 0, M_IDLE, 0, C_RED, C_RED, 4'hA, 8'h0A, 0);
    add_vec(A_SW,   4'h5, 4, M_IDLE, 0, C_RED, C_RED, 4'h5, 8'h0A, 0);
    add_vec(A_PTX,  4'h0, 0, M_TXW,  0, C_GRN, C_RED, 4'h5, 8'h05, 1);
    add_vec(A_TXD,  4'h0, 2, M_TXON, 0, C_BLU, C_RED, 4'h5, 8'h05, 0);
    add_vec(A_PTX,  4'h0, 0, M_IDLE, 0, C_RED, C_RED, 4'h5, 8'h05, 0);
    add_vec(A_BOTH, 4'h0, 0, M_RX,   1, C_RED, C_GRN, 4'h5, 8'h05, 0);
    add_vec(A_PRX,  4'h0, 0, M_IDLE, 0, C_RED, C_RED, 4'h5, 8'h05, 0);
    add_vec(A_RXV,  4'h0, 0, M_IDLE, 0, C_RED, C_RED, 4'h5, 8'h05, 0);
    add_vec(A_TXD,  4'h0, 0, M_IDLE, 0, C_RED, C_RED, 4'h5, 8'h05, 0);

    // Reset state, held and after release.
    repeat (3) tick();
    check_outputs("reset_hold", M_IDLE, 1'b0, C_RED, C_RED, 4'h0, 8'h00);
    check("reset_hold.tx_start", tx_start, 1'b0);
    rst_n = 1'b1;
    tick();
    check_outputs("reset_release", M_IDLE, 1'b0, C_RED, C_RED, 4'h0, 8'h00);
    check("reset_release.tx_start", tx_start, 1'b0);

    // Directed vector table.
    for (int i = 0; i < vecs.size(); i++) begin
      int base;
      base = start_cnt;
      do_action(vecs[i].act, vecs[i].arg, vecs[i].wait_n);
      check_outputs($sformatf("vec%0d", i), vecs[i].st, vecs[i].rx, vecs[i].l5,
                    vecs[i].l6, vecs[i].ld, vecs[i].txd);
      check($sformatf("vec%0d.starts", i), start_cnt - base, vecs[i].starts);
    end

    // Bounce on BTN3: never DEB consecutive equal samples, so no press.
    for (int i = 0; i < 10; i++) begin
      btn[3] = ~btn[3];
      repeat (2) tick();
    end
    btn = 2'b00;
    repeat (10) tick();
    check("bounce.state", state_o, M_IDLE);
    check("bounce.rx_en", rx_en, 1'b0);

    // Asynchronous reset while waiting for the transmitter.
    do_action(A_SW, 4'h3, 4);
    do_action(A_PTX, 4'h0, 0);
    check("midtx.pre_state", state_o, M_TXW);
    #2 rst_n = 1'b0;
    #1;
    check_outputs("midtx_reset", M_IDLE, 1'b0, C_RED, C_RED, 4'h0, 8'h00);
    check("midtx_reset.tx_start", tx_start, 1'b0);
    m_mode = M_IDLE; m_txd = 8'h00; m_hold_tx = 0; m_hold_rx = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    do_action(A_TXD, 4'h0, 1);
    check_model("midtx_late_done");

    // Randomized actions against the mode model.
    for (int i = 0; i < 60; i++) begin
      int act, w;
      act = $urandom_range(0, 6);
      w = $urandom_range(0, 10);
      if (act == A_SW) w = w + 4;
      do_action(act, 4'($urandom_range(0, 15)), w);
      check_model($sformatf("rand%0d_a%0d", i, act));
    end

    repeat (4) tick();
    check("scoreboard.drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
